// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, handler vector, PRId value,
// exception codes, field widths and the mode (EXL) state encoding.
package cp0_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned EXC_W  = 6;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned INT_W  = 6;

  localparam logic [REG_AW-1:0] SR_NUM    = 5'd12;
  localparam logic [REG_AW-1:0] CAUSE_NUM = 5'd13;
  localparam logic [REG_AW-1:0] EPC_NUM   = 5'd14;
  localparam logic [REG_AW-1:0] PRID_NUM  = 5'd15;

  localparam logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [XLEN-1:0] PRID_VAL     = 32'h0000_4C01;

  localparam logic [EXC_W-1:0] EXC_INT  = 6'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 6'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 6'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 6'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 6'd12;

  // EXL is the state bit: NORMAL = 0, HANDLER = 1
  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

endpackage

// File: rtl/cp0_if.sv
// CP0 pipeline-side bus.
// master (pipeline): drives read/write ports and M-stage status, receives
//   dout, epc_out and req.
// slave (cp0): the reverse.
interface cp0_if;

  logic [cp0_pkg::REG_AW-1:0] a1;
  logic [cp0_pkg::REG_AW-1:0] a2;
  logic [cp0_pkg::XLEN-1:0]   din;
  logic                       we;
  logic [cp0_pkg::XLEN-1:0]   pc_m;
  logic [cp0_pkg::EXC_W-1:0]  exccode_m;
  logic                       bd_m;
  logic                       eret_m;
  logic [cp0_pkg::INT_W-1:0]  hwint;
  logic [cp0_pkg::XLEN-1:0]   dout;
  logic [cp0_pkg::XLEN-1:0]   epc_out;
  logic                       req;

  modport master (
    output a1, a2, din, we, pc_m, exccode_m, bd_m, eret_m, hwint,
    input  dout, epc_out, req
  );

  modport slave (
    input  a1, a2, din, we, pc_m, exccode_m, bd_m, eret_m, hwint,
    output dout, epc_out, req
  );

endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR / Cause / EPC / PRId, exception and interrupt entry,
// eret return.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - synchronous active-high reset
//   bus   - cp0_if.slave: mfc0 read (a1 -> dout), mtc0 write (a2/din/we),
//           M-stage pc_m/exccode_m/bd_m/eret_m, hwint lines;
//           outputs dout, epc_out and req (all combinational)
module cp0
  import cp0_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  mode_e              mode_q, mode_d;
  logic [INT_W-1:0]   im_q, im_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [INT_W-1:0]   ip_q, ip_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [XLEN-1:0]    epc_q, epc_d;

  logic exl;
  logic int_req;
  logic exc_req;
  logic take;

  // Exception / interrupt request; nothing is taken inside the handler or during reset
  always_comb begin
    exl     = (mode_q == MODE_HANDLER);
    int_req = (|(bus.hwint & im_q)) & ie_q & ~exl;
    exc_req = (bus.exccode_m != '0) & ~exl;
    take    = (int_req | exc_req) & ~reset;
    bus.req = take;
  end

  // Next-state: exception entry beats mtc0 and eret; eret clears EXL after an SR write
  always_comb begin
    mode_d = mode_q;
    im_d   = im_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ip_d   = bus.hwint;
    code_d = code_q;
    epc_d  = epc_q;
    if (take) begin
      mode_d = MODE_HANDLER;
      bd_d   = bus.bd_m;
      code_d = int_req ? CODE_W'(0) : bus.exccode_m[CODE_W-1:0];
      epc_d  = bus.bd_m ? (bus.pc_m - XLEN'(4)) : bus.pc_m;
    end else begin
      if (bus.we) begin
        if (bus.a2 == SR_NUM) begin
          im_d   = bus.din[15:10];
          mode_d = bus.din[1] ? MODE_HANDLER : MODE_NORMAL;
          ie_d   = bus.din[0];
        end else if (bus.a2 == EPC_NUM) begin
          epc_d = bus.din;
        end
      end
      if (bus.eret_m) begin
        mode_d = MODE_NORMAL;
      end
    end
  end

  // State registers; IP tracks hwint on every edge, including reset
  always_ff @(posedge clk) begin
    ip_q <= ip_d;
    if (reset) begin
      mode_q <= MODE_NORMAL;
      im_q   <= '0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      mode_q <= mode_d;
      im_q   <= im_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // Register read mux (no write bypass)
  always_comb begin
    bus.epc_out = epc_q;
    case (bus.a1)
      SR_NUM:    bus.dout = {16'h0000, im_q, 8'h00, exl, ie_q};
      CAUSE_NUM: bus.dout = {bd_q, 15'h0000, ip_q, 3'b000, code_q, 2'b00};
      EPC_NUM:   bus.dout = epc_q;
      PRID_NUM:  bus.dout = PRID_VAL;
      default:   bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: expectations are queued when the
// stimulus is applied and popped when the matching output is observed.
module tb_cp0;
  import cp0_pkg::*;

  logic clk;
  logic reset;
  cp0_if bus ();

  cp0 dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic got_reg(input logic [4:0] n);
    bus.a1 = n;
    #1;
    got(bus.dout);
  endtask

  task automatic got_req();
    #1;
    got({31'b0, bus.req});
  endtask

  task automatic got_epc_out();
    #1;
    got(bus.epc_out);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.a1        = '0;
    bus.a2        = '0;
    bus.din       = '0;
    bus.we        = 1'b0;
    bus.pc_m      = '0;
    bus.exccode_m = EXC_ADEL;
    bus.bd_m      = 1'b0;
    bus.eret_m    = 1'b0;
    bus.hwint     = '0;

    // req held low while in reset
    push("req_during_reset", 32'd0);
    got_req();
    tick();
    tick();
    reset         = 1'b0;
    bus.exccode_m = '0;

    // Reset state
    push("sr_reset", 32'd0);        got_reg(SR_NUM);
    push("cause_reset", 32'd0);     got_reg(CAUSE_NUM);
    push("epc_reset", 32'd0);       got_reg(EPC_NUM);
    push("epc_out_reset", 32'd0);   got_epc_out();
    push("prid_read", PRID_VAL);    got_reg(PRID_NUM);
    push("unimpl_read", 32'd0);     got_reg(5'd7);

    // Write SR: no bypass in the write cycle
    bus.we  = 1'b1;
    bus.a2  = SR_NUM;
    bus.din = 32'h0000_0401;
    push("sr_no_bypass", 32'd0);    got_reg(SR_NUM);
    tick();
    bus.we = 1'b0;
    push("sr_after_write", 32'h0000_0401); got_reg(SR_NUM);

    // Enabled interrupt taken
    bus.hwint = 6'b000001;
    bus.pc_m  = 32'h0000_3000;
    push("int_req", 32'd1);         got_req();
    push("int_cause", 32'h0000_0400);
    push("int_sr", 32'h0000_0403);
    push("int_epc", 32'h0000_3000);
    tick();
    got_reg(CAUSE_NUM);
    got_reg(SR_NUM);
    got_reg(EPC_NUM);

    // No nesting while EXL=1
    bus.exccode_m = EXC_ADES;
    push("nested_req", 32'd0);      got_req();
    push("nested_epc", 32'h0000_3000);
    push("nested_cause", 32'h0000_0400);
    push("nested_sr", 32'h0000_0403);
    tick();
    bus.exccode_m = '0;
    got_reg(EPC_NUM);
    got_reg(CAUSE_NUM);
    got_reg(SR_NUM);

    // eret returns to NORMAL; the pending interrupt then raises req
    bus.eret_m = 1'b1;
    push("eret_cycle_req", 32'd0);  got_req();
    tick();
    bus.eret_m = 1'b0;
    push("eret_sr", 32'h0000_0401); got_reg(SR_NUM);
    push("pending_int_req", 32'd1); got_req();
    bus.hwint = '0;
    push("int_dropped_req", 32'd0); got_req();

    // Clear SR
    bus.we  = 1'b1;
    bus.a2  = SR_NUM;
    bus.din = 32'd0;
    tick();
    bus.we = 1'b0;

    // AdEL in a delay slot with IE=0
    bus.exccode_m = EXC_ADEL;
    bus.pc_m      = 32'h0000_3010;
    bus.bd_m      = 1'b1;
    push("adel_req", 32'd1);        got_req();
    push("adel_epc", 32'h0000_300C);
    push("adel_cause", 32'h8000_0010);
    push("adel_sr", 32'h0000_0002);
    tick();
    bus.exccode_m = '0;
    bus.bd_m      = 1'b0;
    got_reg(EPC_NUM);
    got_reg(CAUSE_NUM);
    got_reg(SR_NUM);

    bus.eret_m = 1'b1;
    tick();
    bus.eret_m = 1'b0;
    push("eret2_sr", 32'd0);        got_reg(SR_NUM);

    // Exception beats a same-cycle EPC write
    bus.we        = 1'b1;
    bus.a2        = EPC_NUM;
    bus.din       = 32'h0000_1234;
    bus.exccode_m = EXC_OV;
    bus.pc_m      = 32'h0000_3000;
    push("ov_req", 32'd1);          got_req();
    push("ov_epc", 32'h0000_3000);
    push("ov_cause", 32'h0000_0030);
    tick();
    bus.we        = 1'b0;
    bus.exccode_m = '0;
    got_reg(EPC_NUM);
    got_reg(CAUSE_NUM);

    // SR write together with eret: written value, then EXL forced low
    bus.we     = 1'b1;
    bus.a2     = SR_NUM;
    bus.din    = 32'h0000_0403;
    bus.eret_m = 1'b1;
    push("we_eret_sr", 32'h0000_0401);
    tick();
    bus.we     = 1'b0;
    bus.eret_m = 1'b0;
    got_reg(SR_NUM);

    // Exception beats eret
    bus.exccode_m = EXC_RI;
    bus.eret_m    = 1'b1;
    bus.pc_m      = 32'h0000_3020;
    push("ri_req", 32'd1);          got_req();
    push("ri_sr", 32'h0000_0403);
    push("ri_epc", 32'h0000_3020);
    push("ri_cause", 32'h0000_0028);
    tick();
    bus.exccode_m = '0;
    bus.eret_m    = 1'b0;
    got_reg(SR_NUM);
    got_reg(EPC_NUM);
    got_reg(CAUSE_NUM);

    // EPC write inside the handler, epc_out not bypassed
    bus.we  = 1'b1;
    bus.a2  = EPC_NUM;
    bus.din = 32'h0000_3040;
    push("epc_out_no_bypass", 32'h0000_3020); got_epc_out();
    tick();
    push("epc_out_written", 32'h0000_3040);   got_epc_out();

    // Cause is not writable
    bus.a2  = CAUSE_NUM;
    bus.din = 32'hFFFF_FFFF;
    tick();
    bus.we = 1'b0;
    push("cause_write_ignored", 32'h0000_0028); got_reg(CAUSE_NUM);

    // Reset from HANDLER
    reset         = 1'b1;
    bus.exccode_m = EXC_OV;
    push("req_reset_handler", 32'd0); got_req();
    tick();
    reset         = 1'b0;
    bus.exccode_m = '0;
    push("sr_after_reset2", 32'd0);    got_reg(SR_NUM);
    push("epc_after_reset2", 32'd0);   got_reg(EPC_NUM);
    push("cause_after_reset2", 32'd0); got_reg(CAUSE_NUM);
    push("req_after_reset2", 32'd0);   got_req();

    // EPC wraps for a delay-slot fault at pc 0
    bus.exccode_m = EXC_OV;
    bus.pc_m      = 32'd0;
    bus.bd_m      = 1'b1;
    push("wrap_epc", 32'hFFFF_FFFC);
    push("wrap_cause", 32'h8000_0030);
    tick();
    bus.exccode_m = '0;
    bus.bd_m      = 1'b0;
    got_reg(EPC_NUM);
    got_reg(CAUSE_NUM);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 a1  in  5  mfc0 read register number.
REQ-004 a2  in  5  mtc0 write register number.
REQ-005 din  in  32  mtc0 write data.
REQ-006 we  in  1  mtc0 write enable (M stage).
REQ-007 pc_m  in  32  PC of the instruction in M.
REQ-008 exccode_m  in  6  M-stage exception code after address checks; 0 = none.
REQ-009 bd_m  in  1  M instruction is in a branch delay slot.
REQ-010 eret_m  in  1  eret in M.
REQ-011 hwint  in  6  device interrupt lines: timer0, timer1, external, others.
REQ-012 dout  out  32  combinational read of register a1; 0 for unimplemented numbers.
REQ-013 epc_out  out  32  current EPC, combinational.
REQ-014 req  out  1  take exception/interrupt this cycle: flush pipeline, redirect to HANDLER_ADDR.

Function
REQ-015 Registers: SR(12) = {IM[15:10], EXL[1], IE[0]}; Cause(13) = {BD[31], IP[15:10], ExcCode[6:2]}; EPC(14) 32b; PRId(15) = PRID_VAL constant. All other bits read 0.
REQ-016 Mode: two states, NORMAL (EXL=0) and HANDLER (EXL=1); EXL is the state bit.
REQ-017 int_req = |(hwint & IM) & IE & !EXL.
REQ-018 exc_req = (exccode_m != 0) & !EXL.
REQ-019 req = int_req | exc_req, combinational, same cycle as inputs.
REQ-020 On req, interrupt takes priority: ExcCode <= 0 if int_req, else exccode_m[4:0].
REQ-021 On req: EXL <= 1; BD <= bd_m; EPC <= bd_m ? pc_m - 4 : pc_m (32b, wraps modulo 2^32). NORMAL->HANDLER.
REQ-022 On eret_m with no req: EXL <= 0 (HANDLER->NORMAL); EPC is unchanged.
REQ-023 IP[15:10] <= hwint every cycle, regardless of state, mask or req.
REQ-024 mtc0 (we=1, no req): a2=12 writes IM, EXL, IE from din; a2=14 writes EPC <= din; writes to 13, 15 and other numbers are ignored.
REQ-025 Simultaneous events:
  - req beats a we write to the same cycle; the write is dropped.
  - req beats eret_m.
  - we to SR and eret_m in the same cycle: the write value is applied, then EXL is forced to 0.
REQ-026 Reads are not bypassed: dout and epc_out show pre-edge values in the cycle of a write.
REQ-027 While EXL=1, req=0 for any exccode_m or hwint (no nested exceptions).
REQ-028 Latency: req is 0-cycle; register effects are visible on the next cycle.

Reset
REQ-029 On reset: SR=0 (IM=0, EXL=0, IE=0), Cause=0 except IP, which samples hwint on the next edge, EPC=0; the state is NORMAL.
REQ-030 req=0 during the reset cycle; reset overrides req, we and eret_m.
REQ-031 Reset in HANDLER returns to NORMAL with EPC cleared.

Structure
REQ-032 The shared header holds:
  - register numbers SR_NUM=12, CAUSE_NUM=13, EPC_NUM=14, PRID_NUM=15;
  - HANDLER_ADDR=32'h4180;
  - PRID_VAL;
  - exccode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-033 cp0 is a single module with no sub-module; the interrupt priority logic is inline.

Verification
REQ-034 After reset: write SR=32'h0000_0401 (IM[10]=1, IE=1); hwint=6'b000001 -> req=1 that cycle. Next cycle: Cause.ExcCode=0, IP[10]=1, EXL=1, EPC=pc_m.
REQ-035 exccode_m=4 (AdEL), pc_m=32'h3010, bd_m=1, IE=0 -> req=1. Next cycle: EPC=32'h300C, BD=1, ExcCode=4.
REQ-036 With EXL=1, exccode_m=5 and an enabled hwint -> req=0 and no register change. Then eret_m=1 -> EXL=0 next cycle, after which the pending interrupt raises req.
REQ-037 Same cycle: we=1, a2=14, din=32'h1234, with exccode_m=12, pc_m=32'h3000 -> EPC=32'h3000, not 32'h1234.
REQ-038 Reset asserted while EXL=1 and EPC=32'h3040 -> next cycle SR=0, EPC=0, req=0.
REQ-039 Read a1=15 -> dout=PRID_VAL; a1=7 -> dout=0; write a2=13 with din=32'hFFFFFFFF -> Cause unchanged.
